// File: rtl/hamming_deser.sv
// Serial-to-parallel collector for Hamming codewords feeding a small output FIFO.
// Bits arrive MSB (hamming position 1) first; words pass through unmodified.
module hamming_deser #(
    parameter  int IP_BIT = 8,
    parameter  int DEPTH  = 4,
    localparam int CODE_W = IP_BIT + 4,
    localparam int LVL_W  = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic              in_bit,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [CODE_W-1:0] out_code,
    output logic [LVL_W-1:0]  level,
    output logic              overflow
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(CODE_W);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CODE_W - 1);
    localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        COLLECT = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [CODE_W-1:0]   shift_q, shift_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [LVL_W-1:0]    level_q, level_d;
    logic                out_valid_q, out_valid_d;
    logic [CODE_W-1:0]   out_code_q, out_code_d;
    logic                overflow_q, overflow_d;
    logic [CODE_W-1:0]   mem_q [DEPTH];
    logic [CODE_W-1:0]   mem_d [DEPTH];

    logic                push_s;
    logic                pop_s;
    logic                full_s;
    logic                accept_s;
    logic [CODE_W-1:0]   push_word_s;
    logic [CODE_W-1:0]   head_s;

    assign push_word_s = {shift_q[CODE_W-2:0], in_bit};

    // Bit collection FSM: count valid bits and flag the word-completing cycle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shift_d = shift_q;
        push_s  = 1'b0;
        if (in_valid) begin
            shift_d = push_word_s;
        end else begin
            shift_d = shift_q;
        end
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    state_d = COLLECT;
                    cnt_d   = CNT_W'(1);
                end else begin
                    state_d = IDLE;
                end
            end
            COLLECT: begin
                if (in_valid && (cnt_q == LAST_CNT)) begin
                    state_d = IDLE;
                    cnt_d   = {CNT_W{1'b0}};
                    push_s  = 1'b1;
                end else if (in_valid) begin
                    cnt_d   = cnt_q + CNT_W'(1);
                end else begin
                    cnt_d   = cnt_q;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = {CNT_W{1'b0}};
            end
        endcase
    end

    // FIFO bookkeeping; the registered head is precomputed from next-state pointers.
    always_comb begin
        pop_s      = out_valid_q & out_ready;
        full_s     = (level_q == FULL_LVL);
        accept_s   = push_s & (~full_s | pop_s);
        overflow_d = overflow_q | (push_s & full_s & ~pop_s);
        mem_d      = mem_q;
        if (accept_s) begin
            mem_d[wr_ptr_q] = push_word_s;
        end else begin
            mem_d[wr_ptr_q] = mem_q[wr_ptr_q];
        end
        case ({accept_s, pop_s})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
        rd_ptr_d = pop_s    ? (rd_ptr_q + PTR_W'(1)) : rd_ptr_q;
        wr_ptr_d = accept_s ? (wr_ptr_q + PTR_W'(1)) : wr_ptr_q;
        // A word landing in the slot the head moves onto is not in mem_q yet.
        if (accept_s && (rd_ptr_d == wr_ptr_q)) begin
            head_s = push_word_s;
        end else begin
            head_s = mem_q[rd_ptr_d];
        end
        out_valid_d = (level_d != {LVL_W{1'b0}});
        out_code_d  = out_valid_d ? head_s : {CODE_W{1'b0}};
    end

    // Control and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= {CNT_W{1'b0}};
            shift_q     <= {CODE_W{1'b0}};
            rd_ptr_q    <= {PTR_W{1'b0}};
            wr_ptr_q    <= {PTR_W{1'b0}};
            level_q     <= {LVL_W{1'b0}};
            out_valid_q <= 1'b0;
            out_code_q  <= {CODE_W{1'b0}};
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            shift_q     <= shift_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            level_q     <= level_d;
            out_valid_q <= out_valid_d;
            out_code_q  <= out_code_d;
            overflow_q  <= overflow_d;
        end
    end

    // Word storage; contents are only observed through the registered head.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign out_valid = out_valid_q;
    assign out_code  = out_code_q;
    assign level     = level_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_hamming_deser.sv
// Self-checking bench for hamming_deser: directed table, corner sequences and
// randomized traffic compared every cycle against a queue-based reference model.
module tb_hamming_deser;

    localparam int IP_BIT = 8;
    localparam int DEPTH  = 4;
    localparam int CW     = IP_BIT + 4;
    localparam int LVL_W  = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_bit = 1'b0;
    logic          out_ready = 1'b0;
    logic          out_valid;
    logic [CW-1:0] out_code;
    logic [LVL_W-1:0] level;
    logic          overflow;

    int checks = 0;
    int errors = 0;

    // Reference model state: queue of buffered words, partial-word accumulator.
    int mq[$];
    int acc;
    int nbits;
    bit movf;

    typedef struct {
        logic [CW-1:0] code;
        int            stall_at;
        int            stall_len;
        logic [CW-1:0] exp_code;
    } vec_t;

    vec_t vecs[6];

    hamming_deser #(.IP_BIT(IP_BIT), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_bit    (in_bit),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_code  (out_code),
        .level     (level),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_clear();
        mq.delete();
        acc   = 0;
        nbits = 0;
        movf  = 1'b0;
    endtask

    task automatic model_compare();
        chk("level", 32'(level), 32'(mq.size()));
        chk("out_valid", 32'(out_valid), 32'(mq.size() != 0));
        chk("out_code", 32'(out_code), (mq.size() != 0) ? 32'(mq[0]) : 32'h0);
        chk("overflow", 32'(overflow), 32'(movf));
    endtask

    // One clock: drive, update the model with the edge's events, then compare.
    task automatic step(input logic v, input logic b, input logic r);
        in_valid  = v;
        in_bit    = b;
        out_ready = r;
        @(posedge clk);
        if ((mq.size() != 0) && r) void'(mq.pop_front());
        if (v) begin
            acc = ((acc << 1) | int'(b)) & ((1 << CW) - 1);
            nbits++;
            if (nbits == CW) begin
                nbits = 0;
                if (mq.size() < DEPTH) mq.push_back(acc);
                else movf = 1'b1;
            end
        end
        #1;
        model_compare();
    endtask

    task automatic send_word(input logic [CW-1:0] code, input logic r);
        for (int i = CW - 1; i >= 0; i--) step(1'b1, code[i], r);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_out_code", 32'(out_code), 32'h0);
        chk("rst_level", 32'(level), 32'h0);
        chk("rst_overflow", 32'(overflow), 32'h0);
        model_clear();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        vecs[0] = '{code: 12'hA5C, stall_at: 0, stall_len: 0, exp_code: 12'hA5C};
        vecs[1] = '{code: 12'h3C1, stall_at: 5, stall_len: 3, exp_code: 12'h3C1};
        vecs[2] = '{code: 12'hFFF, stall_at: 1, stall_len: 2, exp_code: 12'hFFF};
        vecs[3] = '{code: 12'h000, stall_at: 11, stall_len: 4, exp_code: 12'h000};
        vecs[4] = '{code: 12'h800, stall_at: 6, stall_len: 1, exp_code: 12'h800};
        vecs[5] = '{code: 12'h001, stall_at: 0, stall_len: 0, exp_code: 12'h001};

        model_clear();
        #2;
        do_reset();

        // Directed table: single word with an optional mid-word stall.
        for (int k = 0; k < 6; k++) begin
            do_reset();
            for (int i = CW - 1; i >= 0; i--) begin
                step(1'b1, vecs[k].code[i], 1'b0);
                if ((vecs[k].stall_len != 0) && ((CW - i) == vecs[k].stall_at))
                    for (int s = 0; s < vecs[k].stall_len; s++) step(1'b0, 1'b0, 1'b0);
            end
            chk("tbl_level", 32'(level), 32'h1);
            chk("tbl_code", 32'(out_code), 32'(vecs[k].exp_code));
            step(1'b0, 1'b0, 1'b1);
            chk("tbl_level_after_pop", 32'(level), 32'h0);
        end

        // Push latency with the consumer ready.
        do_reset();
        for (int i = CW - 1; i >= 1; i--) step(1'b1, vecs[0].code[i], 1'b1);
        chk("lat_valid_before", 32'(out_valid), 32'h0);
        step(1'b1, vecs[0].code[0], 1'b1);
        chk("lat_valid", 32'(out_valid), 32'h1);
        chk("lat_code", 32'(out_code), 32'hA5C);
        step(1'b0, 1'b0, 1'b1);
        chk("lat_level_after", 32'(level), 32'h0);

        // Back-to-back words with overflow on the fifth.
        do_reset();
        for (int w = 1; w <= 5; w++) send_word(CW'(w), 1'b0);
        chk("ovf_level", 32'(level), 32'h4);
        chk("ovf_flag", 32'(overflow), 32'h1);
        for (int s = 0; s < 10; s++) begin
            step(1'b0, 1'b0, 1'b0);
            chk("hold_code", 32'(out_code), 32'h001);
        end
        for (int w = 1; w <= 4; w++) begin
            chk("ovf_order", 32'(out_code), 32'(w));
            step(1'b0, 1'b0, 1'b1);
        end
        chk("ovf_empty", 32'(out_valid), 32'h0);
        chk("ovf_sticky", 32'(overflow), 32'h1);

        // Push and pop together while full.
        do_reset();
        for (int w = 1; w <= 4; w++) send_word(CW'(w), 1'b0);
        for (int i = CW - 1; i >= 1; i--) step(1'b1, vecs[1].code[i], 1'b0);
        step(1'b1, vecs[1].code[0], 1'b1);
        chk("full_pp_level", 32'(level), 32'h4);
        chk("full_pp_ovf", 32'(overflow), 32'h0);
        chk("full_pp_head", 32'(out_code), 32'h002);
        for (int s = 0; s < 3; s++) step(1'b0, 1'b0, 1'b1);
        chk("full_pp_last", 32'(out_code), 32'h3C1);
        step(1'b0, 1'b0, 1'b1);

        // Reset in the middle of a word.
        for (int i = CW - 1; i >= CW - 7; i--) step(1'b1, 1'b1, 1'b0);
        do_reset();
        send_word(12'h0F0, 1'b0);
        chk("midrst_level", 32'(level), 32'h1);
        chk("midrst_code", 32'(out_code), 32'h0F0);
        chk("midrst_ovf", 32'(overflow), 32'h0);
        step(1'b0, 1'b0, 1'b1);

        // Randomized traffic against the model.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            step(1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 9) < ((c / 500) % 2 == 0 ? 6 : 2)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
